dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_seq.sv | 165 ++++++++++++++++
 tb/tb_dsp_mac_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer for one DSP slice: streams A/B pairs in, steers OPMODE/CEP and captures P.
// Optional sticky accumulator-overflow flag OVF is built when DSP_MAC_SEQ_OVF_EN is defined.
module dsp_mac_seq #(
    parameter int WIDTH_2 = 18,
    parameter int WIDTH_4 = 48,
    parameter int LEN_W   = 10,
    parameter int OPM_DLY = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [LEN_W-1:0]   LEN,
    input  logic               IN_VALID,
    input  logic [WIDTH_2-1:0] IN_A,
    input  logic [WIDTH_2-1:0] IN_B,
    output logic               IN_READY,
    output logic [WIDTH_2-1:0] DSP_A,
    output logic [WIDTH_2-1:0] DSP_B,
    output logic               DSP_CEA,
    output logic               DSP_CEB,
    output logic               DSP_CEM,
    output logic               DSP_CEOPMODE,
    output logic               DSP_CEP,
    output logic [7:0]         DSP_OPMODE,
    input  logic [WIDTH_4-1:0] DSP_P,
    input  logic               DSP_CARRYOUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH_4-1:0] RESULT
`ifdef DSP_MAC_SEQ_OVF_EN
    ,
    output logic               OVF
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

    localparam int DRN_W = $clog2(OPM_DLY + 3) + 1;
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(OPM_DLY + 2);

    state_t             state_q;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               first_q;
    logic               first_ab_q;
    logic               ce_ab_q;
    logic [WIDTH_2-1:0] a_q, b_q;
    logic [OPM_DLY-1:0] sr_v_q, sr_f_q;
    logic [WIDTH_4-1:0] result_q;
    logic               busy, tap_v, tap_f;

    assign busy   = (state_q != IDLE);
    assign rem_d  = rem_q - 1'b1;
    assign drn_d  = drn_q + 1'b1;
    assign tap_v  = sr_v_q[OPM_DLY-1];
    assign tap_f  = sr_f_q[OPM_DLY-1];

    // Handshake: a pair transfers on a rising edge where IN_VALID & IN_READY; IN_READY depends on state only.
    assign IN_READY     = (state_q == LOAD);
    assign DSP_A        = a_q;
    assign DSP_B        = b_q;
    assign DSP_CEA      = ce_ab_q;
    assign DSP_CEB      = ce_ab_q;
    assign DSP_CEM      = busy;
    assign DSP_CEOPMODE = busy;
    assign DSP_CEP      = tap_v;
    assign DSP_OPMODE   = !busy ? 8'h00 : (tap_f ? 8'h01 : 8'h09);
    assign BUSY         = busy;
    assign DONE         = (state_q == FIN);
    assign RESULT       = result_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            drn_q      <= '0;
            first_q    <= 1'b0;
            first_ab_q <= 1'b0;
            ce_ab_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            ce_ab_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (LEN != '0) begin
                            rem_q   <= LEN;
                            first_q <= 1'b1;
                            state_q <= LOAD;
                        end else begin
                            result_q <= '0;
                            state_q  <= FIN;
                        end
                    end
                end
                LOAD: begin
                    if (IN_VALID) begin
                        a_q        <= IN_A;
                        b_q        <= IN_B;
                        ce_ab_q    <= 1'b1;
                        first_ab_q <= first_q;
                        first_q    <= 1'b0;
                        rem_q      <= rem_d;
                        if (rem_q == LEN_W'(1)) begin
                            drn_q   <= '0;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the last product to reach P through the A, M and P registers.
                    drn_q <= drn_d;
                    if (drn_q == DRAIN_LAST) begin
                        result_q <= DSP_P;
                        state_q  <= FIN;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slot pipeline: each issued pair carries {valid, first} to its OPMODE/CEP slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_v_q <= '0;
            sr_f_q <= '0;
        end else begin
            sr_v_q[0] <= ce_ab_q;
            sr_f_q[0] <= ce_ab_q & first_ab_q;
            for (int i = 1; i < OPM_DLY; i++) begin
                sr_v_q[i] <= sr_v_q[i-1];
                sr_f_q[i] <= sr_f_q[i-1];
            end
        end
    end

`ifdef DSP_MAC_SEQ_OVF_EN
    logic pv_q, ovf_q;

    // pv_q marks the cycle in which P (and the registered CARRYOUT) reflect a valid slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pv_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            pv_q <= tap_v;
            if (state_q == IDLE && START) begin
                ovf_q <= 1'b0;
            end else if (pv_q && DSP_CARRYOUT) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_carryout;
    assign unused_carryout = DSP_CARRYOUT;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: directed vector table, reset/corner sequences and random jobs against a sum-of-products model.
// A behavioural slice model pairs products with CEP slots in issue order; OVF is exercised when DSP_MAC_SEQ_OVF_EN is defined.
module tb_dsp_mac_seq;

    localparam int W2      = 18;
    localparam int W4      = 48;
    localparam int LW      = 10;
    localparam int OPM_DLY = 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [LW-1:0] LEN = '0;
    logic          IN_VALID = 1'b0;
    logic [W2-1:0] IN_A = '0;
    logic [W2-1:0] IN_B = '0;
    logic          IN_READY;
    logic [W2-1:0] DSP_A, DSP_B;
    logic          DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP;
    logic [7:0]    DSP_OPMODE;
    logic [W4-1:0] DSP_P;
    logic          DSP_CARRYOUT;
    logic          BUSY, DONE;
    logic [W4-1:0] RESULT;
`ifdef DSP_MAC_SEQ_OVF_EN
    logic          OVF;
`endif

    dsp_mac_seq #(
        .WIDTH_2(W2), .WIDTH_4(W4), .LEN_W(LW), .OPM_DLY(OPM_DLY)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN),
        .IN_VALID(IN_VALID), .IN_A(IN_A), .IN_B(IN_B), .IN_READY(IN_READY),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB),
        .DSP_CEM(DSP_CEM), .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_CEP(DSP_CEP),
        .DSP_OPMODE(DSP_OPMODE), .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
`ifdef DSP_MAC_SEQ_OVF_EN
        , .OVF(OVF)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- counters / scoreboard state ----------------
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int mon_err = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    int cea_cnt = 0;
    int slot_idx = 0;
    bit prev_done = 1'b0;
    int cea_cyc[$];

    logic [W2-1:0] ja[16];
    logic [W2-1:0] jb[16];
    bit            ovf_inject = 1'b0;

    // ---------------- slice model: products consumed by CEP slots in issue order ----------------
    logic [W4-1:0] prod_q[$];
    logic [W4-1:0] pr, acc;
    int            sidx = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prod_q.delete();
            DSP_P <= '0;
            DSP_CARRYOUT <= 1'b0;
            sidx = 0;
        end else begin
            DSP_CARRYOUT <= 1'b0;
            if (DSP_CEA) prod_q.push_back(W4'(DSP_A) * W4'(DSP_B));
            if (DSP_CEP && prod_q.size() != 0) begin
                pr = prod_q.pop_front();
                if (DSP_OPMODE == 8'h01) begin
                    acc = pr;
                    sidx = 1;
                end else begin
                    acc = DSP_P + pr;
                    sidx++;
                end
                DSP_P <= acc;
                DSP_CARRYOUT <= ovf_inject && (sidx == 2);
            end
        end
    end

    // ---------------- protocol monitor ----------------
    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            cea_cyc.delete();
            slot_idx = 0;
            prev_done = 1'b0;
        end else begin
            if (DSP_CEA) begin
                cea_cyc.push_back(cyc);
                cea_cnt++;
            end
            if (DSP_CEA !== DSP_CEB) mon_err++;
            if (DSP_CEP) begin
                if (cea_cyc.size() == 0) mon_err++;
                else if (cea_cyc[0] + OPM_DLY != cyc) mon_err++;
                else void'(cea_cyc.pop_front());
                if (DSP_OPMODE !== ((slot_idx == 0) ? 8'h01 : 8'h09)) mon_err++;
                if (DSP_CEOPMODE !== 1'b1) mon_err++;
                slot_idx++;
            end else if (BUSY && DSP_OPMODE !== 8'h09) begin
                mon_err++;
            end
            if (DSP_CEM !== BUSY) mon_err++;
            if (DONE && prev_done) mon_err++;
            if (DONE) done_cnt++;
            if (IN_READY) ready_cnt++;
            prev_done = DONE;
            if (!BUSY) slot_idx = 0;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        string             name;
        int                len;
        int                gap;
        bit                busy_start;
        logic [W4-1:0]     expv;
        logic [3:0][W2-1:0] a;
        logic [3:0][W2-1:0] b;
    } vec_t;

    vec_t vecs[8];
    int   nvec = 0;

    task automatic add_vec(input string nm, input int len, input int gap, input bit bs,
                           input logic [W4-1:0] expv,
                           input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3);
        vecs[nvec].name = nm;
        vecs[nvec].len = len;
        vecs[nvec].gap = gap;
        vecs[nvec].busy_start = bs;
        vecs[nvec].expv = expv;
        vecs[nvec].a[0] = W2'(a0); vecs[nvec].b[0] = W2'(b0);
        vecs[nvec].a[1] = W2'(a1); vecs[nvec].b[1] = W2'(b1);
        vecs[nvec].a[2] = W2'(a2); vecs[nvec].b[2] = W2'(b2);
        vecs[nvec].a[3] = W2'(a3); vecs[nvec].b[3] = W2'(b3);
        nvec++;
    endtask

    // ---------------- check / driver tasks ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    endtask

    task automatic send_pair(input logic [W2-1:0] a, input logic [W2-1:0] b, output bit ok);
        bit rdy;
        int n;
        rdy = 1'b0;
        n = 0;
        IN_VALID = 1'b1;
        IN_A = a;
        IN_B = b;
        while (!rdy && n < 50) begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end
        IN_VALID = 1'b0;
        ok = rdy;
    endtask

    task automatic run_job(input int len, input int gap, input bit rand_gap,
                           input bit busy_start, output bit tmo);
        bit ok;
        int g, n;
        tmo = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1;
        LEN = LW'(len);
        @(posedge CLK); #1;
        START = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (busy_start && k == 1) begin
                START = 1'b1;
                LEN = LW'(1);
            end
            send_pair(ja[k], jb[k], ok);
            if (!ok) begin
                tmo = 1'b1;
                break;
            end
            g = rand_gap ? int'($urandom_range(0, 3)) : gap;
            if (k != len - 1) repeat (g) begin @(posedge CLK); #1; end
        end
        START = 1'b0;
        n = 0;
        if (!tmo) begin
            do begin
                @(negedge CLK);
                n++;
            end while (!DONE && n < 100);
            if (!DONE) tmo = 1'b1;
        end
        #1;
    endtask

    task automatic job_checks(input string nm, input logic [W4-1:0] expv, input int len,
                              input bit tmo, input int done0, input int cea0, input int mon0);
        check({nm, "_timeout"}, 64'(tmo), 64'd0);
        check({nm, "_result"}, 64'(RESULT), 64'(expv));
        check({nm, "_done_cnt"}, 64'(done_cnt - done0), 64'd1);
        check({nm, "_issue_cnt"}, 64'(cea_cnt - cea0), 64'(len));
        check({nm, "_slot_rules"}, 64'(mon_err - mon0), 64'd0);
        check({nm, "_slots_pending"}, 64'(cea_cyc.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit            tmo, ok;
        int            done0, cea0, mon0, ready0, len;
        logic [W4-1:0] expv;

        add_vec("no_bubble",  4, 0, 1'b0, 48'd100,          1, 2, 3, 4, 5, 6, 7, 8);
        add_vec("bubbles",    3, 2, 1'b0, 48'd68,           2, 3, 4, 5, 6, 7, 0, 0);
        add_vec("single",     1, 0, 1'b0, 48'd81,           9, 9, 0, 0, 0, 0, 0, 0);
        add_vec("busy_start", 3, 1, 1'b1, 48'd1400,         10, 10, 20, 20, 30, 30, 0, 0);
        add_vec("max_ops",    2, 0, 1'b0, 48'd137437904898, 262143, 262143, 262143, 262143, 0, 0, 0, 0);
        add_vec("zeros",      4, 1, 1'b0, 48'd1,            0, 5, 5, 0, 1, 1, 0, 0);

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ctrl", 64'({BUSY, DONE, IN_READY, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP, DSP_OPMODE}), 64'd0);
        check("rst_data", 64'({DSP_A, DSP_B}), 64'd0);
        check("rst_result", 64'(RESULT), 64'd0);

        // First state change only at the first rising edge after release
        @(posedge CLK); #1;
        START = 1'b1;
        LEN = '0;
        #2;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_release_idle", 64'({BUSY, DONE}), 64'd0);
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("rst_first_edge", 64'({BUSY, DONE}), 64'b11);
        #1;

        // Directed table (consecutive rows also exercise back-to-back START)
        for (int i = 0; i < nvec; i++) begin
            for (int k = 0; k < 4; k++) begin
                ja[k] = vecs[i].a[k];
                jb[k] = vecs[i].b[k];
            end
            done0 = done_cnt; cea0 = cea_cnt; mon0 = mon_err;
            run_job(vecs[i].len, vecs[i].gap, 1'b0, vecs[i].busy_start, tmo);
            job_checks(vecs[i].name, vecs[i].expv, vecs[i].len, tmo, done0, cea0, mon0);
        end

        // LEN=0: DONE on the next cycle, RESULT forced to 0, no IN_READY
        ready0 = ready_cnt;
        @(posedge CLK); #1;
        START = 1'b1;
        LEN = '0;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        check("len0_done", 64'(DONE), 64'd1);
        check("len0_result", 64'(RESULT), 64'd0);
        @(negedge CLK);
        check("len0_single_pulse", 64'(DONE), 64'd0);
        #1;
        check("len0_no_ready", 64'(ready_cnt - ready0), 64'd0);

        // Random jobs against the sum-of-products model
        for (int j = 0; j < 20; j++) begin
            len = int'($urandom_range(1, 8));
            expv = '0;
            for (int k = 0; k < len; k++) begin
                ja[k] = W2'($urandom_range(0, (1 << W2) - 1));
                jb[k] = W2'($urandom_range(0, (1 << W2) - 1));
                expv = expv + W4'(ja[k]) * W4'(jb[k]);
            end
            done0 = done_cnt; cea0 = cea_cnt; mon0 = mon_err;
            run_job(len, 0, 1'b1, 1'b0, tmo);
            job_checks($sformatf("rand%0d", j), expv, len, tmo, done0, cea0, mon0);
        end

        // Reset in the middle of a 5-pair job after 2 pairs
        for (int k = 0; k < 5; k++) begin
            ja[k] = W2'(k + 1);
            jb[k] = W2'(k + 2);
        end
        @(posedge CLK); #1;
        START = 1'b1;
        LEN = LW'(5);
        @(posedge CLK); #1;
        START = 1'b0;
        send_pair(ja[0], jb[0], ok);
        send_pair(ja[1], jb[1], ok);
        check("rst_mid_pairs_taken", 64'(ok), 64'd1);
        #3;
        RST_N = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({BUSY, DONE, IN_READY, DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP, DSP_OPMODE}), 64'd0);
        check("rst_mid_data", 64'({DSP_A, DSP_B}), 64'd0);
        check("rst_mid_result", 64'(RESULT), 64'd0);
        done0 = done_cnt;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        #1;
        check("rst_mid_no_done", 64'(done_cnt - done0), 64'd0);
        check("rst_mid_idle", 64'(BUSY), 64'd0);
        check("rst_mid_result_held", 64'(RESULT), 64'd0);

        ja[0] = W2'(9);
        jb[0] = W2'(9);
        done0 = done_cnt; cea0 = cea_cnt; mon0 = mon_err;
        run_job(1, 0, 1'b0, 1'b0, tmo);
        job_checks("post_rst", 48'd81, 1, tmo, done0, cea0, mon0);

`ifdef DSP_MAC_SEQ_OVF_EN
        // Carry on slot 2 sets OVF; the next START clears it
        ovf_inject = 1'b1;
        ja[0] = W2'(3); jb[0] = W2'(3);
        ja[1] = W2'(4); jb[1] = W2'(4);
        done0 = done_cnt; cea0 = cea_cnt; mon0 = mon_err;
        run_job(2, 0, 1'b0, 1'b0, tmo);
        job_checks("ovf_job", 48'd25, 2, tmo, done0, cea0, mon0);
        check("ovf_set", 64'(OVF), 64'd1);
        ovf_inject = 1'b0;
        ja[0] = W2'(1); jb[0] = W2'(1);
        done0 = done_cnt; cea0 = cea_cnt; mon0 = mon_err;
        run_job(1, 0, 1'b0, 1'b0, tmo);
        job_checks("ovf_next", 48'd1, 1, tmo, done0, cea0, mon0);
        check("ovf_cleared", 64'(OVF), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
